// File: rtl/pc_next_unit.sv
// pc_next_unit: program counter register plus next-PC selection.
//
// Next-PC sources, highest priority first: a redirect captured during a stall,
// jump, taken branch (branch_i & zero_i), return-stack pop, sequential
// increment. A jump or taken branch seen while stalled is captured, so it is
// not lost, and is applied on the first unstalled edge.
//
// Optional feature: define PC_RAS_EN to build a RAS_DEPTH-entry circular
// return-address stack. Without it, call_i/ret_i are ignored and ras_err_o
// is tied low.
//
// Ports:
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   stall_i           hold PC this cycle
//   branch_i, zero_i  conditional branch, taken when both are high
//   branch_target_i   branch target
//   jump_i            unconditional jump
//   jump_target_i     jump target
//   call_i            qualifies jump_i as a call (push return address)
//   ret_i             return request (pop)
//   pc_o              current PC (registered)
//   pc_seq_o          pc_o + INC, combinational, modulo 2^WIDTH
//   redirect_o        one cycle high after PC loaded from a non-sequential source
//   pending_o         a captured redirect is waiting
//   ras_err_o         sticky return-stack overflow/underflow
module pc_next_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       INC       = 4,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             zero_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_seq_o,
  output logic             redirect_o,
  output logic             pending_o,
  output logic             ras_err_o
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             pending_q, pending_d;
  logic             redirect_q, redirect_d;

  logic br_taken, run;
  logic take_pend, take_jump, take_br, ret_row, take_ret;
  logic             ras_valid;
  logic [WIDTH-1:0] ras_top;

  assign pc_seq_o = pc_q + WIDTH'(INC);
  assign br_taken = branch_i & zero_i;
  assign run      = ~stall_i;

  // Row decode for an unstalled edge; exactly one of these (or none) is high.
  assign take_pend = run & pending_q;
  assign take_jump = run & ~pending_q & jump_i;
  assign take_br   = run & ~pending_q & ~jump_i & br_taken;
  assign ret_row   = run & ~pending_q & ~jump_i & ~br_taken & ret_i;
  assign take_ret  = ret_row & ras_valid;

  always_comb begin
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    pending_d  = pending_q;
    redirect_d = 1'b0;
    if (stall_i) begin
      // Only the first redirect seen during a stall is kept.
      if (!pending_q && (jump_i || br_taken)) begin
        pending_d = 1'b1;
        tgt_d     = jump_i ? jump_target_i : branch_target_i;
      end
    end else if (take_pend) begin
      pc_d       = tgt_q;
      pending_d  = 1'b0;
      redirect_d = 1'b1;
    end else if (take_jump) begin
      pc_d       = jump_target_i;
      redirect_d = 1'b1;
    end else if (take_br) begin
      pc_d       = branch_target_i;
      redirect_d = 1'b1;
    end else if (take_ret) begin
      pc_d       = ras_top;
      redirect_d = 1'b1;
    end else begin
      pc_d = pc_seq_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      pending_q  <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      pending_q  <= pending_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc_o       = pc_q;
  assign pending_o  = pending_q;
  assign redirect_o = redirect_q;

`ifdef PC_RAS_EN
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0]  ptr_q;  // next write slot; when full it points at the oldest entry
  logic [CntW-1:0]  cnt_q;
  logic             err_q;
  logic             push, full;

  assign push      = take_jump & call_i;
  assign full      = (cnt_q == CntW'(RAS_DEPTH));
  assign ras_valid = (cnt_q != '0);
  assign ras_top   = ras_q[ptr_q - 1'b1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (push) begin
      ras_q[ptr_q] <= pc_seq_o;
      ptr_q        <= ptr_q + 1'b1;
      if (full) err_q <= 1'b1;
      else      cnt_q <= cnt_q + 1'b1;
    end else if (take_ret) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end else if (ret_row) begin
      // Underflow: the return fell through to the sequential row.
      err_q <= 1'b1;
    end
  end

  assign ras_err_o = err_q;
`else
  logic unused_ras;
  assign ras_valid  = 1'b0;
  assign ras_top    = '0;
  assign ras_err_o  = 1'b0;
  assign unused_ras = call_i | ret_row;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, zero, jump, call, ret;
  logic [31:0] btgt, jtgt;
  logic [31:0] pc, pc_seq;
  logic        redirect, pending, ras_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_next_unit #(
    .WIDTH    (32),
    .INC      (4),
    .RESET_PC (32'h0),
    .RAS_DEPTH(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .branch_i       (branch),
    .zero_i         (zero),
    .branch_target_i(btgt),
    .jump_i         (jump),
    .jump_target_i  (jtgt),
    .call_i         (call),
    .ret_i          (ret),
    .pc_o           (pc),
    .pc_seq_o       (pc_seq),
    .redirect_o     (redirect),
    .pending_o      (pending),
    .ras_err_o      (ras_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; branch = 0; zero = 0; jump = 0; call = 0; ret = 0;
    btgt = '0; jtgt = '0;
  endtask

  task automatic goto(input logic [31:0] t);
    jump = 1; jtgt = t;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_redirect", {31'b0, redirect}, 32'h0);
    check("rst_pending", {31'b0, pending}, 32'h0);
    check("rst_ras_err", {31'b0, ras_err}, 32'h0);
    check("rst_pc_seq", pc_seq, 32'h4);
    @(negedge clk);
    rst_n = 1;

    // Sequential run out of reset.
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_pc", pc, 32'(4 * i));
      check("seq_redirect", {31'b0, redirect}, 32'h0);
    end

    // Taken branch at 0x10.
    branch = 1; zero = 1; btgt = 32'h40;
    step();
    check("br_taken_pc", pc, 32'h40);
    check("br_taken_redirect", {31'b0, redirect}, 32'h1);
    idle();
    step();
    check("br_after_pc", pc, 32'h44);
    check("br_after_redirect", {31'b0, redirect}, 32'h0);

    // Not-taken branch at 0x10.
    goto(32'h10);
    branch = 1; zero = 0; btgt = 32'h40;
    step();
    check("br_not_taken_pc", pc, 32'h14);
    check("br_not_taken_redirect", {31'b0, redirect}, 32'h0);
    idle();

    // Jump and taken branch together: jump wins.
    jump = 1; jtgt = 32'h60; branch = 1; zero = 1; btgt = 32'h70;
    step();
    check("jmp_vs_br_pc", pc, 32'h60);
    idle();

    // Stall with two jumps: first captured target wins.
    goto(32'h20);
    stall = 1; jump = 1; jtgt = 32'h80;
    step();
    check("stall1_pc", pc, 32'h20);
    check("stall1_pending", {31'b0, pending}, 32'h1);
    check("stall1_redirect", {31'b0, redirect}, 32'h0);
    jtgt = 32'h90;
    step();
    check("stall2_pc", pc, 32'h20);
    check("stall2_pending", {31'b0, pending}, 32'h1);
    jump = 0;
    step();
    check("stall3_pc", pc, 32'h20);
    // Release with a competing taken branch, which must be ignored.
    stall = 0; branch = 1; zero = 1; btgt = 32'h300;
    step();
    check("release_pc", pc, 32'h80);
    check("release_pending", {31'b0, pending}, 32'h0);
    check("release_redirect", {31'b0, redirect}, 32'h1);
    idle();
    step();
    check("release_next_pc", pc, 32'h84);

    // Branch captured during a stall.
    stall = 1; branch = 1; zero = 1; btgt = 32'h50;
    step();
    check("stall_br_pc", pc, 32'h84);
    idle();
    step();
    check("stall_br_release_pc", pc, 32'h50);

    // Wrap past 2^32-4.
    goto(32'hFFFF_FFFC);
    check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pre_seq", pc_seq, 32'h0);
    step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_seq", pc_seq, 32'h4);

    // Reset while a redirect is pending discards it.
    stall = 1; jump = 1; jtgt = 32'hAB0;
    step();
    check("pre_rst_pending", {31'b0, pending}, 32'h1);
    rst_n = 0;
    #1;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_pending", {31'b0, pending}, 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1;
    step();
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_redirect", {31'b0, redirect}, 32'h0);

    // CALL without JUMP and RET are no-ops for the sequence here.
    call = 1;
    step();
    check("call_nojump_pc", pc, 32'h8);
    idle();

`ifdef PC_RAS_EN
    goto(32'h100);
    jump = 1; call = 1; jtgt = 32'h200;
    step();
    check("call_pc", pc, 32'h200);
    idle();
    ret = 1;
    step();
    check("ret_pc", pc, 32'h104);
    check("ret_redirect", {31'b0, redirect}, 32'h1);
    idle();

    goto(32'h1000);
    for (int i = 0; i < 5; i++) begin
      jump = 1; call = 1; jtgt = 32'h2000 + 32'(i) * 32'h100;
      step();
      check("nest_call_pc", pc, 32'h2000 + 32'(i) * 32'h100);
      check("nest_call_err", {31'b0, ras_err}, (i == 4) ? 32'h1 : 32'h0);
    end
    idle();
    ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("nest_ret_pc", pc, 32'h2304 - 32'(i) * 32'h100);
    end
    step();
    check("nest_ret5_pc", pc, 32'h2008);
    check("nest_ret5_redirect", {31'b0, redirect}, 32'h0);
    check("nest_ret5_err", {31'b0, ras_err}, 32'h1);
    idle();
`else
    ret = 1;
    step();
    check("ret_noras_pc", pc, 32'hC);
    check("ret_noras_err", {31'b0, ras_err}, 32'h0);
    idle();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
